// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - sequences output-layer weight updates through an external datapath
module backprop_sequencer #(
    parameter int N_HIDDEN = 4,
    parameter int IDX_W    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             zero_weights_i,
    input  logic             ld_en_i,
    input  logic [IDX_W-1:0] ld_idx_i,
    input  logic [7:0]       ld_data_i,
    input  logic             dp_done_i,
    input  logic [7:0]       dp_w_i,
    output logic             dp_en_o,
    output logic             dp_clr_o,
    output logic [IDX_W-1:0] dp_sel_o,
    output logic [7:0]       dp_w_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             supp_q, supp_d;
    logic [7:0]       bank_q [N_HIDDEN];
    logic             dp_en_q, dp_clr_q, busy_q, done_q;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_data;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        supp_d  = supp_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_data = dp_w_i;
        case (state_q)
            S_IDLE: begin
                if (ld_en_i) begin
                    wr_en   = 1'b1;
                    wr_idx  = ld_idx_i;
                    wr_data = ld_data_i;
                end
                if (start_i) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                supp_d  = 1'b0;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A late done on the final allowed WAIT cycle still wins over the timeout
                if (dp_done_i) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        supp_d  = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wr_en = !supp_q;
                if (idx_q == IDX_W'(N_HIDDEN - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (zero_weights_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            supp_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // Output flags are registered from the next state so they line up with state_q
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            supp_q   <= 1'b0;
            dp_en_q  <= 1'b0;
            dp_clr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < N_HIDDEN; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            supp_q   <= supp_d;
            dp_en_q  <= (state_d == S_ISSUE);
            dp_clr_q <= (state_d == S_CLEAR);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_FINISH);
            if (zero_weights_i) begin
                for (int i = 0; i < N_HIDDEN; i++) begin
                    bank_q[i] <= '0;
                end
            end else if (wr_en) begin
                bank_q[wr_idx] <= wr_data;
            end
        end
    end

    assign dp_en_o   = dp_en_q;
    assign dp_clr_o  = dp_clr_q;
    assign dp_sel_o  = idx_q;
    assign dp_w_o    = bank_q[idx_q];
    assign rd_data_o = bank_q[rd_idx_i];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb/tb_backprop_sequencer.sv - self-checking bench for backprop_sequencer
module tb_backprop_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 15;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic          zero_weights_i = 1'b0;
    logic          ld_en_i = 1'b0;
    logic [IW-1:0] ld_idx_i = '0;
    logic [7:0]    ld_data_i = '0;
    logic          dp_done_i = 1'b0;
    logic [7:0]    dp_w_i = '0;
    logic          dp_en_o, dp_clr_o, busy_o, done_o, err_o;
    logic [IW-1:0] dp_sel_o;
    logic [7:0]    dp_w_o, rd_data_o;
    logic [IW-1:0] rd_idx_i = '0;

    int         tests = 0;
    int         fails = 0;
    int         lat [N];
    logic [7:0] wval [N];
    logic [7:0] mbank [N];
    int         dcnt = 0;
    bit         active = 1'b0;

    backprop_sequencer #(.N_HIDDEN(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .zero_weights_i(zero_weights_i),
        .ld_en_i(ld_en_i), .ld_idx_i(ld_idx_i), .ld_data_i(ld_data_i),
        .dp_done_i(dp_done_i), .dp_w_i(dp_w_i), .dp_en_o(dp_en_o), .dp_clr_o(dp_clr_o),
        .dp_sel_o(dp_sel_o), .dp_w_o(dp_w_o), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Datapath model: raises done on WAIT cycle lat[idx]+1 after its enable pulse
    always @(negedge clk_i) begin
        dp_w_i = wval[dp_sel_o];
        if (!busy_o || dp_clr_o) begin
            active    = 1'b0;
            dp_done_i = 1'b0;
        end else if (dp_en_o) begin
            active    = 1'b1;
            dcnt      = 0;
            dp_done_i = 1'b0;
        end else if (active) begin
            dp_done_i = (dcnt >= lat[dp_sel_o]);
            dcnt++;
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx_i = IW'(i);
            #1;
            check($sformatf("%s bank[%0d]", tag, i), 32'(rd_data_o), 32'(mbank[i]));
        end
    endtask

    task automatic load(input int i, input logic [7:0] d);
        ld_en_i = 1'b1; ld_idx_i = IW'(i); ld_data_i = d;
        tick();
        ld_en_i = 1'b0;
        mbank[i] = d;
    endtask

    task automatic run_pass(input string tag, input bit inject);
        int len, ticks, dones, done_tick, ens, clrs, w;
        bit merr;
        len = 2; merr = 1'b0;
        for (int i = 0; i < N; i++) begin
            w = (lat[i] + 1 > TO) ? TO : lat[i] + 1;
            len += 3 + w;
            if (lat[i] + 1 <= TO) mbank[i] = wval[i];
            else merr = 1'b1;
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ticks = 1; dones = 0; done_tick = -1; ens = 0; clrs = 0;
        while (busy_o && ticks < 400) begin
            if (done_o) begin
                dones++;
                if (done_tick < 0) done_tick = ticks;
            end
            ens  += int'(dp_en_o);
            clrs += int'(dp_clr_o);
            if (inject && ticks == 5) begin
                start_i = 1'b1; ld_en_i = 1'b1;
                ld_idx_i = IW'($urandom_range(0, N - 1)); ld_data_i = 8'($urandom);
            end
            if (inject && ticks == 8) begin
                start_i = 1'b0; ld_en_i = 1'b0;
            end
            tick();
            ticks++;
        end
        check({tag, " done cycle"}, 32'(done_tick), 32'(len - 1));
        check({tag, " done pulses"}, 32'(dones), 32'd1);
        check({tag, " pass length"}, 32'(ticks), 32'(len));
        check({tag, " enable pulses"}, 32'(ens), 32'(N));
        check({tag, " clear pulses"}, 32'(clrs), 32'(N));
        check({tag, " err"}, 32'(err_o), 32'(merr));
        check_bank(tag);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            lat[i] = 0; wval[i] = '0; mbank[i] = '0;
        end

        // Reset state
        tick(); tick();
        check("in reset busy", 32'(busy_o), 32'd0);
        check("in reset dp_en", 32'(dp_en_o), 32'd0);
        rst_i = 1'b1;
        tick();
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset dp_clr", 32'(dp_clr_o), 32'd0);
        check("reset dp_sel", 32'(dp_sel_o), 32'd0);
        check_bank("reset");

        // Nominal pass: load {10,20,30,40}, datapath returns idx+100 immediately
        for (int i = 0; i < N; i++) load(i, 8'(10 * (i + 1)));
        check_bank("loaded");
        for (int i = 0; i < N; i++) begin
            lat[i] = 0; wval[i] = 8'(100 + i);
        end
        run_pass("nominal", 1'b0);

        // Datapath stalls forever on idx 2
        for (int i = 0; i < N; i++) wval[i] = 8'($urandom);
        lat[2] = 1000;
        run_pass("timeout idx2", 1'b0);

        // Timeout boundary: last allowed WAIT cycle vs one beyond
        lat[0] = TO - 1; lat[1] = TO; lat[2] = 0; lat[3] = TO - 2;
        for (int i = 0; i < N; i++) wval[i] = 8'($urandom);
        run_pass("boundary", 1'b0);

        // Randomized latencies and weights
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < N; i++) begin
                lat[i] = $urandom_range(0, TO + 2);
                wval[i] = 8'($urandom);
            end
            run_pass($sformatf("random%0d", p), 1'b0);
        end

        // Restart and load attempts during a pass are ignored
        for (int i = 0; i < N; i++) begin
            lat[i] = $urandom_range(0, 3); wval[i] = 8'($urandom);
        end
        run_pass("restart ignored", 1'b1);

        // zero_weights mid-pass
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        zero_weights_i = 1'b1; tick(); zero_weights_i = 1'b0;
        for (int i = 0; i < N; i++) mbank[i] = '0;
        check("zero busy", 32'(busy_o), 32'd0);
        check("zero dp_sel", 32'(dp_sel_o), 32'd0);
        check_bank("zero");
        begin
            int dn = 0;
            for (int k = 0; k < 20; k++) begin
                dn += int'(done_o);
                tick();
            end
            check("zero no done", 32'(dn), 32'd0);
        end

        // Reset during WAIT of idx 1
        for (int i = 0; i < N; i++) load(i, 8'($urandom_range(1, 255)));
        for (int i = 0; i < N; i++) begin
            lat[i] = 0; wval[i] = 8'($urandom);
        end
        lat[1] = 30;
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre-reset sel", 32'(dp_sel_o), 32'd1);
        check("pre-reset busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0; tick();
        check("mid reset busy", 32'(busy_o), 32'd0);
        check("mid reset outs", 32'({dp_en_o, dp_clr_o, done_o, err_o, dp_sel_o, dp_w_o}), 32'd0);
        rst_i = 1'b1; tick();
        for (int i = 0; i < N; i++) mbank[i] = '0;
        check_bank("mid reset");

        // zero_weights, ld_en and start together in IDLE
        for (int i = 0; i < N; i++) load(i, 8'($urandom_range(1, 255)));
        zero_weights_i = 1'b1; ld_en_i = 1'b1; start_i = 1'b1;
        ld_idx_i = 2'd1; ld_data_i = 8'h5A;
        tick();
        zero_weights_i = 1'b0; ld_en_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < N; i++) mbank[i] = '0;
        check("combo busy", 32'(busy_o), 32'd0);
        tick();
        check("combo stays idle", 32'(busy_o), 32'd0);
        check_bank("combo");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
